// File: rtl/avg_pkg.sv
// Shared types and constants for the averager result path.
package avg_pkg;

    localparam int DW  = 16;
    localparam int WIN = 12;

    typedef logic [DW-1:0] data_t;

    // Minimum tracker starts at the largest value so the first capture always wins.
    localparam data_t STATS_MIN_INIT = '1;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO. The head word is held in a register loaded from the
// storage array at the next read pointer, so a pushed word is visible one cycle
// after its push edge and the array keeps a registered read port.
module sync_fifo #(
    parameter int DW    = 16,
    parameter int DEPTH = 16,
    parameter int CW    = 5
) (
    input  logic          clk,
    input  logic          srst,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0] count_reg, count_next;
    logic [DW-1:0] dout_reg;
    logic          pop_ok;
    logic          push_ok;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == CW'(DEPTH));
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign count   = count_reg;
    assign dout    = dout_reg;

    // Pointer and occupancy next-state; pointers wrap naturally at DEPTH.
    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (push_ok) begin
            wr_ptr_next = wr_ptr_reg + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_next = rd_ptr_reg + 1'b1;
        end
        if (push_ok && !pop_ok) begin
            count_next = count_reg + 1'b1;
        end else if (pop_ok && !push_ok) begin
            count_next = count_reg - 1'b1;
        end
    end

    // Storage array write port; contents need no reset because occupancy gates their use.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    // Head register: bypass the incoming word when it becomes the new head,
    // otherwise read the array at the next read pointer.
    always_ff @(posedge clk) begin
        if (srst) begin
            dout_reg <= '0;
        end else if (count_next == '0) begin
            dout_reg <= '0;
        end else if (push_ok && (wr_ptr_reg == rd_ptr_next)) begin
            dout_reg <= din;
        end else begin
            dout_reg <= mem[rd_ptr_next];
        end
    end

endmodule

// File: rtl/avg_result_fifo.sv
// Decimates the free-running averager result stream, buffers captures in a
// show-ahead FIFO for a stallable host, and tracks min/max plus a sticky overflow.
module avg_result_fifo #(
    parameter int DW    = 16,
    parameter int DEPTH = 16,
    parameter int DECIM = 1,
    parameter int CW    = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          avg_ready,
    input  logic [DW-1:0] avg_dout,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    input  logic          out_ready,
    output logic [CW-1:0] count,
    output logic          overflow,
    output logic [DW-1:0] min_val,
    output logic [DW-1:0] max_val,
    output logic          stats_valid
);

    import avg_pkg::*;

    localparam int DCW = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [DW-1:0] MIN_INIT = (DW == $bits(data_t)) ? DW'(STATS_MIN_INIT) : {DW{1'b1}};

    logic [DCW-1:0] dcnt_reg, dcnt_next;
    logic           overflow_reg;
    logic [DW-1:0]  min_reg;
    logic [DW-1:0]  max_reg;
    logic           stats_valid_reg;

    logic           flush;
    logic           cap;
    logic           push;
    logic           pop;
    logic           full;
    logic           empty;

    // Reset and clear are equivalent flushes and dominate everything else.
    assign flush = reset || clear;
    assign cap   = avg_ready && (dcnt_reg == DCW'(DECIM - 1));
    assign pop   = !empty && out_ready;
    assign push  = cap && (!full || pop);

    assign out_valid   = !empty;
    assign overflow    = overflow_reg;
    assign min_val     = min_reg;
    assign max_val     = max_reg;
    assign stats_valid = stats_valid_reg;

    // Decimation counter advances only while the averager result is valid.
    always_comb begin
        dcnt_next = dcnt_reg;
        if (avg_ready) begin
            dcnt_next = cap ? '0 : dcnt_reg + 1'b1;
        end
    end

    // Decimation counter register.
    always_ff @(posedge clk) begin
        if (flush) begin
            dcnt_reg <= '0;
        end else begin
            dcnt_reg <= dcnt_next;
        end
    end

    // Sticky overflow: set when a capture finds the FIFO full with no pop to make room.
    always_ff @(posedge clk) begin
        if (flush) begin
            overflow_reg <= 1'b0;
        end else if (cap && full && !pop) begin
            overflow_reg <= 1'b1;
        end
    end

    // Running unsigned min/max over every capture, including dropped ones.
    always_ff @(posedge clk) begin
        if (flush) begin
            min_reg         <= MIN_INIT;
            max_reg         <= '0;
            stats_valid_reg <= 1'b0;
        end else if (cap) begin
            if (avg_dout < min_reg) begin
                min_reg <= avg_dout;
            end
            if (avg_dout > max_reg) begin
                max_reg <= avg_dout;
            end
            stats_valid_reg <= 1'b1;
        end
    end

    sync_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk   (clk),
        .srst  (flush),
        .push  (push),
        .pop   (pop),
        .din   (avg_dout),
        .dout  (out_data),
        .full  (full),
        .empty (empty),
        .count (count)
    );

endmodule
